hline_setup: RTL and testbench
==============================

# hline_setup

Span setup stage that sits directly upstream of the horizontal-line z-buffer engine. It accepts one span command (endpoints, depths, colour, row) over a valid/ready handshake. It orders the endpoints and computes the Bresenham-style depth parameters with a serial 32-cycle divider, and derives framebuffer and z-buffer start addresses. It then pulses `start` to the engine and waits for its `done` before taking the next command.

## Interface
Parameters:
- `STRIDE`, 640: pixels per row; one pixel is one 32-bit word.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `nreset`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  span command present
- `cmd_ready`  out  1  block can accept a command
- `x1`, `x2`  in  16 each  span endpoints, unsigned pixel columns
- `y`  in  16  row, unsigned
- `z1_in`, `z2_in`  in  32 each  depths at `x1`/`x2`, signed two's complement
- `rgbx_in`  in  32  span colour
- `fb_base`, `zbuff_base`  in  32 each  byte base addresses, sampled at accept
- `start`  out  1  one-cycle go pulse to the line engine
- `fb_addr`, `zbuff_addr`  out  32 each  byte address of leftmost pixel
- `dx`  out  32  span length, `xr - xl`
- `slope`  out  32  signed integer quotient `dz/dx`
- `rem`  out  32  `|dz| mod dx`
- `err`  out  32  initial error term, always 0
- `z1`  out  32  depth at leftmost pixel
- `rgbx`  out  32  registered colour
- `done`  in  1  level from the line engine; high while the engine is in its terminal state
- `busy`  out  1  high whenever the state is not IDLE
- `span_done`  out  1  one-cycle pulse when a span retires
- `span_count`  out  16  spans retired since reset; wraps from 0xFFFF to 0

## Operation
- States and transitions:
  - IDLE → SETUP on accept.
  - SETUP → DIVIDE, or SETUP → RETIRE if `dx == 0`.
  - DIVIDE → ISSUE after 32 iterations.
  - ISSUE → WAIT_LOW → WAIT_HIGH → RETIRE → IDLE.
- `cmd_ready` equals (state == IDLE). A command is accepted when `cmd_valid & cmd_ready` at a clock edge. All inputs, including bases, are registered on accept.
- SETUP:
  - If `x2 < x1`, swap the endpoints together with their depths. The result is `xl`, `xr`, `zl`, `zr`.
  - `dx = xr - xl`, zero-extended to 32 bits.
  - `dz = zr - zl`, 32-bit wrap.
  - `neg` = `dz[31]`; `mag = |dz|`.
  - `pix = y*STRIDE + xl`, 32-bit product truncated.
  - `fb_addr = fb_base + (pix<<2)`; `zbuff_addr = zbuff_base + (pix<<2)`.
  - `z1 = zl`.
- DIVIDE: radix-2 restoring unsigned division `mag / dx[15:0]`, one quotient bit per cycle, MSB first, exactly 32 cycles. Then:
  - `slope` = `neg ? -q : q`.
  - `rem` = remainder (unsigned, always < `dx`).
  - `err` = 0.
- ISSUE: `start` = 1 for exactly this cycle.
- WAIT_LOW: stay until `done == 0`. This absorbs a stale `done` left high from the previous span.
- WAIT_HIGH: stay until `done == 1`.
- RETIRE: `span_done` = 1 for one cycle and `span_count` += 1. For the `dx == 0` case, `start` is never asserted.
- Output hold: `fb_addr`, `zbuff_addr`, `dx`, `slope`, `rem`, `err`, `z1`, `rgbx` are registers. They change only in SETUP or DIVIDE and stay stable from ISSUE through RETIRE.
- Reset (asynchronous, any state, including mid-divide or mid-wait):
  - State = IDLE, all outputs and registers = 0, `cmd_ready` = 1 after release.
  - No `start` or `span_done` pulse is produced by the aborted span.

## Timing
- Accept at edge T0 (state IDLE → SETUP). SETUP occupies cycle 1, DIVIDE cycles 2–33, ISSUE (`start` high) cycle 34.
- Minimum WAIT_LOW + WAIT_HIGH is 2 cycles.
- Earliest `span_done` is cycle 37, relative to the accept edge.
- Degenerate span (`dx == 0`): `span_done` in cycle 2; `cmd_ready` high again in cycle 3.
- Back-to-back: the next accept is possible on the edge after RETIRE. There are no bubbles beyond the states listed.
- `done` is sampled only in WAIT_LOW and WAIT_HIGH; its value in all other states is ignored.
- `cmd_valid` may be held high across the whole operation; only one command is consumed per IDLE visit.

## Test plan
- Forward span: `x1=10`, `x2=110`, `z1_in=1000`, `z2_in=1350`, `y=2`, `fb_base=0x10000000`, `zbuff_base=0x20000000` → `dx=100`, `slope=3`, `rem=50`, `err=0`, `z1=1000`, `fb_addr=0x10001428`, `zbuff_addr=0x20001428`; `start` pulses at cycle 34.
- Reversed endpoints: same span with `x1=110`, `x2=10`, `z1_in=1350`, `z2_in=1000` → outputs identical to the forward span.
- Negative slope: `x1=0`, `x2=7`, `z1_in=100`, `z2_in=77`, `y=0` → `dx=7`, `slope=0xFFFFFFFD`, `rem=2`, `z1=100`.
- Degenerate: `x1=x2=5` → `start` never asserted, `span_done` in cycle 2, `span_count` +1.
- Handshake with stale `done`:
  - Drive `done=1` continuously until 3 cycles after `start`, then 0 for 10 cycles, then 1.
  - Required: `span_done` only after the second rising `done`.
  - Required: a second queued command is accepted the cycle after RETIRE.
- Reset mid-operation: assert `nreset=0` at cycle 20 (in DIVIDE) → all outputs read 0 immediately. After release, `cmd_ready=1`, no `start` pulse occurs, `span_count=0`.

Source files
------------

// File: rtl/hline_setup.sv
// Span setup stage for the horizontal-line z-buffer engine: orders endpoints, divides dz by dx
// serially, derives start addresses, then hands the span to the engine and waits for it.
module hline_setup #(
  parameter int unsigned STRIDE = 640
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic [15:0] y,
  input  logic [31:0] z1_in,
  input  logic [31:0] z2_in,
  input  logic [31:0] rgbx_in,
  input  logic [31:0] fb_base,
  input  logic [31:0] zbuff_base,
  output logic        start,
  output logic [31:0] fb_addr,
  output logic [31:0] zbuff_addr,
  output logic [31:0] dx,
  output logic [31:0] slope,
  output logic [31:0] rem,
  output logic [31:0] err,
  output logic [31:0] z1,
  output logic [31:0] rgbx,
  input  logic        done,
  output logic        busy,
  output logic        span_done,
  output logic [15:0] span_count
);

  localparam logic [31:0] StrideW = 32'(STRIDE);

  typedef enum logic [2:0] {
    StIdle, StSetup, StDivide, StIssue, StWaitLow, StWaitHigh, StRetire
  } state_e;

  state_e state_q, state_d;

  logic [15:0] x1_q, x2_q, y_q;
  logic [31:0] za_q, zb_q, rgbx_q, fbb_q, zbb_q;

  logic [31:0] quo_q;
  logic [15:0] prem_q;
  logic        neg_q;
  logic [4:0]  cnt_q;

  logic        swap;
  logic [15:0] xl, xr, span_len;
  logic [31:0] zl, zr, dz, mag, pix, offs;
  logic [16:0] prem_sh;
  logic        fits;
  logic [15:0] prem_nx;
  logic [31:0] quo_nx;

  always_comb begin
    swap     = x2_q < x1_q;
    xl       = swap ? x2_q : x1_q;
    xr       = swap ? x1_q : x2_q;
    zl       = swap ? zb_q : za_q;
    zr       = swap ? za_q : zb_q;
    span_len = xr - xl;
    dz       = zr - zl;
    mag      = dz[31] ? -dz : dz;
    pix      = {16'd0, y_q} * StrideW + {16'd0, xl};
    offs     = pix << 2;
  end

  // Restoring division step: the dividend shifts out of quo_q MSB first while quotient bits
  // shift in at the bottom; the partial remainder always stays below dx, so 16 bits hold it.
  always_comb begin
    prem_sh = {prem_q, quo_q[31]};
    fits    = prem_sh >= {1'b0, dx[15:0]};
    prem_nx = fits ? 16'(prem_sh - {1'b0, dx[15:0]}) : prem_sh[15:0];
    quo_nx  = {quo_q[30:0], fits};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (cmd_valid) state_d = StSetup;
      StSetup:    state_d = (span_len == 16'd0) ? StRetire : StDivide;
      StDivide:   if (cnt_q == 5'd31) state_d = StIssue;
      StIssue:    state_d = StWaitLow;
      StWaitLow:  if (!done) state_d = StWaitHigh;
      StWaitHigh: if (done) state_d = StRetire;
      StRetire:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    start     = (state_q == StIssue);
    span_done = (state_q == StRetire);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= StIdle;
      x1_q       <= '0;
      x2_q       <= '0;
      y_q        <= '0;
      za_q       <= '0;
      zb_q       <= '0;
      rgbx_q     <= '0;
      fbb_q      <= '0;
      zbb_q      <= '0;
      quo_q      <= '0;
      prem_q     <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      fb_addr    <= '0;
      zbuff_addr <= '0;
      dx         <= '0;
      slope      <= '0;
      rem        <= '0;
      err        <= '0;
      z1         <= '0;
      rgbx       <= '0;
      span_count <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            x1_q   <= x1;
            x2_q   <= x2;
            y_q    <= y;
            za_q   <= z1_in;
            zb_q   <= z2_in;
            rgbx_q <= rgbx_in;
            fbb_q  <= fb_base;
            zbb_q  <= zbuff_base;
          end
        end
        StSetup: begin
          dx         <= {16'd0, span_len};
          z1         <= zl;
          fb_addr    <= fbb_q + offs;
          zbuff_addr <= zbb_q + offs;
          rgbx       <= rgbx_q;
          slope      <= '0;
          rem        <= '0;
          err        <= '0;
          neg_q      <= dz[31];
          quo_q      <= mag;
          prem_q     <= '0;
          cnt_q      <= '0;
        end
        StDivide: begin
          quo_q  <= quo_nx;
          prem_q <= prem_nx;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            slope <= neg_q ? -quo_nx : quo_nx;
            rem   <= {16'd0, prem_nx};
            err   <= '0;
          end
        end
        StRetire: span_count <= span_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hline_setup.sv
// Directed bench for hline_setup: forward/reversed/negative/degenerate spans, stale done
// handshake with a queued command, and asynchronous reset in the middle of a divide.
module tb_hline_setup;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] x1 = '0, x2 = '0, y = '0;
  logic [31:0] z1_in = '0, z2_in = '0, rgbx_in = '0, fb_base = '0, zbuff_base = '0;
  logic        start;
  logic [31:0] fb_addr, zbuff_addr, dx, slope, rem, err, z1, rgbx;
  logic        done = 1'b0;
  logic        busy;
  logic        span_done;
  logic [15:0] span_count;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_count = '0;

  hline_setup #(.STRIDE(640)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .x1         (x1),
    .x2         (x2),
    .y          (y),
    .z1_in      (z1_in),
    .z2_in      (z2_in),
    .rgbx_in    (rgbx_in),
    .fb_base    (fb_base),
    .zbuff_base (zbuff_base),
    .start      (start),
    .fb_addr    (fb_addr),
    .zbuff_addr (zbuff_addr),
    .dx         (dx),
    .slope      (slope),
    .rem        (rem),
    .err        (err),
    .z1         (z1),
    .rgbx       (rgbx),
    .done       (done),
    .busy       (busy),
    .span_done  (span_done),
    .span_count (span_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    end
  endtask

  // Drives one command and returns 1 time unit after the accepting edge.
  task automatic send(input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] ay,
                      input logic [31:0] az1, input logic [31:0] az2, input logic [31:0] argb,
                      input logic [31:0] afb, input logic [31:0] azb, input bit hold);
    @(negedge clk);
    check_eq("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    check_eq("count_before_accept", {16'd0, span_count}, {16'd0, exp_count});
    x1 = a1; x2 = a2; y = ay; z1_in = az1; z2_in = az2;
    rgbx_in = argb; fb_base = afb; zbuff_base = azb;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Follows a span from cycle 1 to RETIRE. done is set low lo cycles and high hi cycles after
  // the start cycle; returns at the negedge of the retire cycle.
  task automatic track_span(input string nm, input int lo, input int hi,
                            input logic [31:0] e_dx, input logic [31:0] e_sl,
                            input logic [31:0] e_rm, input logic [31:0] e_z1,
                            input logic [31:0] e_fb, input logic [31:0] e_zb,
                            input logic [31:0] e_rgb);
    int sc, rc, starts;
    sc = 0; rc = 0; starts = 0;
    for (int c = 1; c <= 120 && rc == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_eq({nm, "_busy_c1"}, {31'd0, busy}, 32'd1);
        check_eq({nm, "_ready_c1"}, {31'd0, cmd_ready}, 32'd0);
      end
      if (start) begin
        starts++;
        if (sc == 0) begin
          sc = c;
          check_eq({nm, "_dx"}, dx, e_dx);
          check_eq({nm, "_slope"}, slope, e_sl);
          check_eq({nm, "_rem"}, rem, e_rm);
          check_eq({nm, "_err"}, err, 32'd0);
          check_eq({nm, "_z1"}, z1, e_z1);
          check_eq({nm, "_fb_addr"}, fb_addr, e_fb);
          check_eq({nm, "_zb_addr"}, zbuff_addr, e_zb);
          check_eq({nm, "_rgbx"}, rgbx, e_rgb);
        end
      end
      if (sc != 0 && c == sc + lo) done = 1'b0;
      if (sc != 0 && c == sc + hi) done = 1'b1;
      if (span_done) begin
        rc = c;
        check_eq({nm, "_slope_hold"}, slope, e_sl);
        check_eq({nm, "_fb_hold"}, fb_addr, e_fb);
        check_eq({nm, "_count_at_retire"}, {16'd0, span_count}, {16'd0, exp_count});
        exp_count = exp_count + 16'd1;
      end
    end
    check_eq({nm, "_start_cycle"}, sc, 34);
    check_eq({nm, "_start_pulses"}, starts, 1);
    check_eq({nm, "_retire_cycle"}, rc, 34 + hi + 1);
  endtask

  initial begin
    int starts, dones;

    repeat (3) @(negedge clk);
    check_eq("rst_dx", dx, 32'd0);
    check_eq("rst_slope", slope, 32'd0);
    check_eq("rst_fb_addr", fb_addr, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_start", {31'd0, start}, 32'd0);
    check_eq("rst_count", {16'd0, span_count}, 32'd0);
    nreset = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Forward: pix = 2*640+10 = 1290, byte offset 5160 = 0x1428; 350/100 = 3 r 50.
    send(16'd10, 16'd110, 16'd2, 32'd1000, 32'd1350, 32'hAABBCCDD,
         32'h1000_0000, 32'h2000_0000, 1'b0);
    track_span("fwd", 1, 2, 32'd100, 32'd3, 32'd50, 32'd1000,
               32'h1000_1428, 32'h2000_1428, 32'hAABBCCDD);
    done = 1'b0;

    send(16'd110, 16'd10, 16'd2, 32'd1350, 32'd1000, 32'hAABBCCDD,
         32'h1000_0000, 32'h2000_0000, 1'b0);
    track_span("rev", 1, 2, 32'd100, 32'd3, 32'd50, 32'd1000,
               32'h1000_1428, 32'h2000_1428, 32'hAABBCCDD);
    done = 1'b0;

    // dz = -23, 23/7 = 3 r 2.
    send(16'd0, 16'd7, 16'd0, 32'd100, 32'd77, 32'h11223344,
         32'h1000_0000, 32'h2000_0000, 1'b0);
    track_span("neg", 1, 2, 32'd7, 32'hFFFF_FFFD, 32'd2, 32'd100,
               32'h1000_0000, 32'h2000_0000, 32'h11223344);
    done = 1'b0;

    // Degenerate: pix = 3*640+5 = 1925, byte offset 7700 = 0x1E14.
    send(16'd5, 16'd5, 16'd3, 32'd42, 32'd99, 32'h55667788,
         32'h1000_0000, 32'h2000_0000, 1'b0);
    @(negedge clk);
    check_eq("deg_c1_start", {31'd0, start}, 32'd0);
    check_eq("deg_c1_span_done", {31'd0, span_done}, 32'd0);
    @(negedge clk);
    check_eq("deg_c2_span_done", {31'd0, span_done}, 32'd1);
    check_eq("deg_c2_start", {31'd0, start}, 32'd0);
    check_eq("deg_dx", dx, 32'd0);
    check_eq("deg_z1", z1, 32'd42);
    check_eq("deg_fb_addr", fb_addr, 32'h1000_1E14);
    exp_count = exp_count + 16'd1;
    @(negedge clk);
    check_eq("deg_c3_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("deg_count", {16'd0, span_count}, {16'd0, exp_count});

    // Stale done with cmd_valid held: the second command must enter right after RETIRE.
    done = 1'b1;
    send(16'd10, 16'd110, 16'd2, 32'd1000, 32'd1350, 32'hAABBCCDD,
         32'h1000_0000, 32'h2000_0000, 1'b1);
    track_span("stale", 3, 13, 32'd100, 32'd3, 32'd50, 32'd1000,
               32'h1000_1428, 32'h2000_1428, 32'hAABBCCDD);
    x1 = 16'd0; x2 = 16'd7; y = 16'd0; z1_in = 32'd100; z2_in = 32'd77;
    rgbx_in = 32'h11223344;
    @(negedge clk);
    check_eq("b2b_ready_after_retire", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    track_span("b2b", 3, 5, 32'd7, 32'hFFFF_FFFD, 32'd2, 32'd100,
               32'h1000_0000, 32'h2000_0000, 32'h11223344);
    done = 1'b0;

    // Reset in the middle of the divide.
    send(16'd10, 16'd110, 16'd2, 32'd1000, 32'd1350, 32'hAABBCCDD,
         32'h1000_0000, 32'h2000_0000, 1'b0);
    repeat (20) @(negedge clk);
    nreset = 1'b0;
    #1;
    check_eq("mid_rst_dx", dx, 32'd0);
    check_eq("mid_rst_z1", z1, 32'd0);
    check_eq("mid_rst_fb_addr", fb_addr, 32'd0);
    check_eq("mid_rst_zb_addr", zbuff_addr, 32'd0);
    check_eq("mid_rst_rgbx", rgbx, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_count", {16'd0, span_count}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    exp_count = '0;
    starts = 0;
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (start) starts++;
      if (span_done) dones++;
    end
    check_eq("post_rst_starts", starts, 0);
    check_eq("post_rst_span_dones", dones, 0);
    check_eq("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("post_rst_count", {16'd0, span_count}, {16'd0, exp_count});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
